// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS HI/LO unit (shift-add multiply, restoring divide).
// Optional feature macro MDU_EARLY_OUT_EN: multiplies leave RUN once no multiplier bits remain.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             ResetN,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} mduStateT;

  mduStateT state, stateNext;

  logic [CW-1:0]    counter;
  logic             primed;
  logic             opIsDiv;
  logic             signA;
  logic             signB;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH-1:0] accHi;
  logic [WIDTH-1:0] accLo;

  logic             inNegA;
  logic             inNegB;
  logic [WIDTH-1:0] inAbsA;
  logic [WIDTH-1:0] inAbsB;
  logic             lastIter;
  logic             divZero;

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH-1:0] mulHiNext;
  logic [WIDTH-1:0] mulLoNext;
  logic [WIDTH:0]   divShift;
  logic             divOk;
  logic [WIDTH-1:0] divHiNext;
  logic [WIDTH-1:0] divLoNext;

  logic [2*WIDTH-1:0] prodRaw;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   resHi;
  logic [WIDTH-1:0]   resLo;

`ifdef MDU_EARLY_OUT_EN
  logic [WIDTH-1:0] remaining;
`endif

  // Signed ops work on magnitudes; the signs are reapplied in FIX.
  assign inNegA   = Op[0] & OperandA[WIDTH-1];
  assign inNegB   = Op[0] & OperandB[WIDTH-1];
  assign inAbsA   = inNegA ? -OperandA : OperandA;
  assign inAbsB   = inNegB ? -OperandB : OperandB;
  assign lastIter = (counter == CW'(WIDTH - 1));
  assign divZero  = (absB == '0);
  assign Busy     = (state != IDLE);

  assign addend    = accLo[0] ? absA : '0;
  assign mulSum    = {1'b0, accHi} + {1'b0, addend};
  assign mulHiNext = mulSum[WIDTH:1];
  assign mulLoNext = {mulSum[0], accLo[WIDTH-1:1]};

  assign divShift  = {accHi, accLo[WIDTH-1]};
  assign divOk     = (divShift >= {1'b0, absB});
  assign divHiNext = divOk ? (divShift[WIDTH-1:0] - absB) : divShift[WIDTH-1:0];
  assign divLoNext = {accLo[WIDTH-2:0], divOk};

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (Start) stateNext = RUN;
      RUN: begin
        if (!primed) begin
`ifdef MDU_EARLY_OUT_EN
          if (!opIsDiv && divZero) stateNext = FIX;
`endif
        end else if (lastIter) begin
          stateNext = FIX;
`ifdef MDU_EARLY_OUT_EN
        end else if (!opIsDiv && (remaining[WIDTH-1:1] == '0)) begin
          stateNext = FIX;
`endif
        end
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= stateNext;
  end

  // A shortened multiply leaves the product shifted up by the skipped iterations.
`ifdef MDU_EARLY_OUT_EN
  assign prodRaw = {accHi, accLo} >> (CW'(WIDTH) - counter);
`else
  assign prodRaw = {accHi, accLo};
`endif
  assign product = (signA ^ signB) ? -prodRaw : prodRaw;

  always_comb begin
    resHi = '0;
    resLo = '0;
    if (opIsDiv) begin
      if (divZero) begin
        resHi = signA ? -absA : absA;
        resLo = '1;
      end else begin
        resHi = signA ? -accHi : accHi;
        resLo = (signA ^ signB) ? -accLo : accLo;
      end
    end else begin
      {resHi, resLo} = product;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      counter <= '0;
      primed  <= 1'b0;
      opIsDiv <= 1'b0;
      signA   <= 1'b0;
      signB   <= 1'b0;
      absA    <= '0;
      absB    <= '0;
      accHi   <= '0;
      accLo   <= '0;
`ifdef MDU_EARLY_OUT_EN
      remaining <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            opIsDiv <= Op[1];
            signA   <= inNegA;
            signB   <= inNegB;
            absA    <= inAbsA;
            absB    <= inAbsB;
            counter <= '0;
            primed  <= 1'b0;
          end
        end
        RUN: begin
          // First RUN cycle seeds the accumulator from the latched magnitudes.
          if (!primed) begin
            primed <= 1'b1;
            accHi  <= '0;
            accLo  <= opIsDiv ? absA : absB;
`ifdef MDU_EARLY_OUT_EN
            remaining <= absB;
`endif
          end else begin
            counter <= counter + 1'b1;
            if (opIsDiv) begin
              accHi <= divHiNext;
              accLo <= divLoNext;
            end else begin
              accHi <= mulHiNext;
              accLo <= mulLoNext;
            end
`ifdef MDU_EARLY_OUT_EN
            remaining <= remaining >> 1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // mthi/mtlo only land while idle; FIX commits the finished result.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Hi <= '0;
      Lo <= '0;
    end else if (state == IDLE) begin
      if (HiWrite) Hi <= WriteData;
      if (LoWrite) Lo <= WriteData;
    end else if (state == FIX) begin
      Hi <= resHi;
      Lo <= resLo;
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
    end else begin
      Done      <= (state == FIX);
      DivByZero <= (state == FIX) && opIsDiv && divZero;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table-driven and randomized checks of mult_div_unit
// against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int WIDTH = 32;
`ifdef MDU_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              ResetN;
  logic              Start;
  logic [1:0]        Op;
  logic [WIDTH-1:0]  OperandA;
  logic [WIDTH-1:0]  OperandB;
  logic              HiWrite;
  logic              LoWrite;
  logic [WIDTH-1:0]  WriteData;
  logic              Busy;
  logic              Done;
  logic              DivByZero;
  logic [WIDTH-1:0]  Hi;
  logic [WIDTH-1:0]  Lo;

  int vectorCount = 0;
  int missCount   = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
    logic        expDz;
  } vecT;

  mult_div_unit #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Op(Op),
    .OperandA(OperandA), .OperandB(OperandB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
    .Busy(Busy), .Done(Done), .DivByZero(DivByZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  function automatic vecT makeVector(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    vecT v;
    longint sa, sb, q, r;
    logic [63:0] p;
    v.op = op; v.a = a; v.b = b; v.expDz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: p = 64'(sa * sb);
      2'b10: p = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
      default: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {32'(r), 32'(q)};
        end
      end
    endcase
    v.expHi = p[63:32];
    v.expLo = p[31:0];
    v.expDz = op[1] && (b == 0);
    return v;
  endfunction

  function automatic int expLatency(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] m;
    int lat;
    lat = WIDTH + 2;
    if (EarlyOut && !op[1]) begin
      m = (op[0] && b[31]) ? -b : b;
      lat = 2;
      for (int i = 0; i < WIDTH; i++) if (m[i]) lat = i + 3;
    end
    return lat;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    Op = op; OperandA = a; OperandB = b; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Called just after the launch edge; counts edges until Done (bounded).
  task automatic waitDone(input int restartAt, output int latency, output int busyCycles, output logic dz);
    latency = -1;
    busyCycles = Busy ? 1 : 0;
    dz = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (k == restartAt) begin
        Start = 1'b1; Op = 2'b10; OperandA = 32'd5; OperandB = 32'd3;
      end
      @(negedge Clk);
      Start = 1'b0;
      if (Busy) busyCycles++;
      if (Done) begin
        latency = k;
        dz = DivByZero;
        break;
      end
    end
  endtask

  task automatic countDone(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(negedge Clk);
      if (Done) n++;
    end
  endtask

  task automatic runVector(input vecT v, input int restartAt);
    int lat, busyCycles;
    logic dz;
    applyStimulus(v.op, v.a, v.b);
    waitDone(restartAt, lat, busyCycles, dz);
    checkOutput("latency", 32'(lat), 32'(expLatency(v.op, v.b)));
    checkOutput("busyCycles", 32'(busyCycles), 32'(expLatency(v.op, v.b)));
    checkOutput("Hi", Hi, v.expHi);
    checkOutput("Lo", Lo, v.expLo);
    checkOutput("DivByZero", {31'b0, dz}, {31'b0, v.expDz});
    @(negedge Clk);
    checkOutput("DoneClear", {30'b0, Done, DivByZero}, 32'd0);
  endtask

  vecT table_[10];

  initial begin
    int n, lat, busyCycles;
    logic dz;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    table_[0] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    table_[1] = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    table_[2] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    table_[3] = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    table_[4] = '{2'b10, 32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1};
    table_[5] = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    table_[6] = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    table_[7] = '{2'b11, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
    table_[8] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    table_[9] = '{2'b00, 32'd5,        32'd3,        32'd0,        32'd15,       1'b0};

    ResetN = 1'b0; Start = 1'b0; Op = 2'b00; OperandA = '0; OperandB = '0;
    HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
    #12;
    checkOutput("resetHi", Hi, 32'd0);
    checkOutput("resetLo", Lo, 32'd0);
    checkOutput("resetFlags", {29'b0, Busy, Done, DivByZero}, 32'd0);
    @(negedge Clk);
    ResetN = 1'b1;

    for (int i = 0; i < 10; i++) runVector(table_[i], 0);

    // Second Start during the busy window must be dropped, not queued.
    runVector(table_[1], 10);
    countDone(45, n);
    checkOutput("noExtraDone", 32'(n), 32'd0);
    checkOutput("ignoredStartHi", Hi, 32'hFFFFFFFF);

    // mthi/mtlo while idle, separately and together.
    @(negedge Clk); HiWrite = 1'b1; WriteData = 32'hAAAA0000;
    @(negedge Clk); HiWrite = 1'b0; LoWrite = 1'b1; WriteData = 32'h00005555;
    checkOutput("mthi", Hi, 32'hAAAA0000);
    @(negedge Clk); LoWrite = 1'b0;
    checkOutput("mtlo", Lo, 32'h00005555);

    // Reset in the middle of DIVU 100/7 discards the operation.
    applyStimulus(2'b10, 32'd100, 32'd7);
    repeat (4) @(negedge Clk);
    HiWrite = 1'b1; WriteData = 32'hDEADBEEF;
    @(negedge Clk); HiWrite = 1'b0;
    repeat (8) @(negedge Clk);
    checkOutput("holdHi", Hi, 32'hAAAA0000);
    checkOutput("holdLo", Lo, 32'h00005555);
    checkOutput("midBusy", {31'b0, Busy}, 32'd1);
    @(negedge Clk); ResetN = 1'b0;
    #1;
    checkOutput("abortHi", Hi, 32'd0);
    checkOutput("abortLo", Lo, 32'd0);
    checkOutput("abortBusy", {31'b0, Busy}, 32'd0);
    @(negedge Clk); ResetN = 1'b1;
    countDone(40, n);
    checkOutput("abortNoDone", 32'(n), 32'd0);
    runVector(table_[5], 0);

    // mthi together with Start: Hi takes WriteData, then the product.
    @(negedge Clk);
    Start = 1'b1; Op = 2'b00; OperandA = 32'd6; OperandB = 32'd7;
    HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hCAFEF00D;
    @(negedge Clk);
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    checkOutput("startMthiHi", Hi, 32'hCAFEF00D);
    checkOutput("startMtloLo", Lo, 32'hCAFEF00D);
    waitDone(0, lat, busyCycles, dz);
    checkOutput("startMthiLat", 32'(lat), 32'(expLatency(2'b00, 32'd7)));
    checkOutput("startMthiResHi", Hi, 32'd0);
    checkOutput("startMthiResLo", Lo, 32'd42);

    runVector(makeVector(2'b00, 32'd5, 32'd0), 0);

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(3));
      ra = $urandom;
      case ($urandom_range(7))
        0: rb = 32'd0;
        1: rb = $urandom_range(15);
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(5) == 0) ra = 32'h80000000;
      runVector(makeVector(rop, ra, rb), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit in the MIPS execute path.
- Operands come directly from the register file's two read ports (ReadData1 -> OperandA, ReadData2 -> OperandB).
- Hi/Lo results are consumed by the writeback mux for mfhi/mflo.
- The hazard/stall logic uses Busy to stall mfhi/mflo/mthi/mtlo and any new mult/div.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- Clk  input  1  clock, positive-edge.
- ResetN  input  1  asynchronous, active-low reset.
- Start  input  1  launch operation; sampled only when Busy=0.
- Op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- OperandA  input  WIDTH  rs value: multiplicand or dividend.
- OperandB  input  WIDTH  rt value: multiplier or divisor.
- HiWrite  input  1  mthi strobe.
- LoWrite  input  1  mtlo strobe.
- WriteData  input  WIDTH  data for mthi/mtlo.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse when Hi/Lo take the new result.
- DivByZero  output  1  valid with Done; divisor was zero.
- Hi  output  WIDTH  HI register (product high half / remainder).
- Lo  output  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (ResetN=0, async): Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0; FSM=IDLE; counter=0; operand and sign latches cleared.
  - Reset mid-operation aborts; no partial result reaches Hi/Lo.
- FSM: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - Start=1 at edge E0 latches Op, |OperandA|, |OperandB| and the result sign bits.
    - Absolute values apply only for signed ops; unsigned ops latch operands as-is.
  - Busy=1 and FSM=RUN from E0.
- RUN: one iteration per cycle for exactly WIDTH cycles.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter counts 0..WIDTH-1, then FSM=FIX.
- FIX: one cycle.
  - Apply sign correction: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
  - At the following edge (E34 for WIDTH=32): Hi/Lo load the result, Done=1 for exactly one cycle, Busy=0, FSM=IDLE.
- Latency: Start edge to Done = WIDTH+2 cycles; Busy high for WIDTH+2 cycles.
- Hi/Lo hold their previous values throughout RUN/FIX.
- Start while Busy=1: ignored; no queuing.
- Division by zero (OperandB=0, DIV or DIVU):
  - Full latency is still taken.
  - Result: Hi=OperandA (original, unsigned view), Lo={WIDTH{1}}.
  - DivByZero=1 with Done; cleared the next cycle.
- DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0; no trap.
- HiWrite/LoWrite:
  - When Busy=0: Hi/Lo <= WriteData at the next edge.
  - When Busy=1: ignored (stall logic guarantees absence).
  - HiWrite and Start in the same IDLE cycle: Hi is written; the operation also starts and its result overwrites Hi at Done.
  - HiWrite and LoWrite together: both written.
- Done and DivByZero are registered outputs; all state updates occur on the rising edge of Clk.

Optional Feature:
- MDU_EARLY_OUT_EN
  - Defined: for MULT/MULTU, RUN exits to FIX as soon as the remaining (shifted) multiplier bits are all zero; accumulator alignment is corrected in FIX. Latency = (index of highest set multiplier bit + 1) + 2 cycles, minimum 2 (multiplier 0 -> Done at E2, Hi=Lo=0). Division timing unchanged.
  - Undefined: fixed WIDTH+2 latency for all ops; early-out logic absent.

Test Plan:
- Reset; MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Busy 34 cycles, Done once; Hi=0xFFFFFFFE, Lo=0x00000001; DivByZero=0.
- MULT 0xFFFFFFFD (-3) x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; second Start pulsed at cycle 10 ignored; exactly one Done.
- DIV 0xFFFFFFF9 (-7) / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU 0x1234 / 0 -> after 34 cycles Hi=0x1234, Lo=0xFFFFFFFF, DivByZero=1 for one cycle with Done.
- mthi 0xAAAA0000 and mtlo 0x5555 while idle -> Hi/Lo updated next edge; start DIVU 100/7, assert ResetN=0 at cycle 15 -> Hi=Lo=0, Busy=0, no Done; restart after reset -> Lo=14, Hi=2.
- With MDU_EARLY_OUT_EN: MULTU 5 x 3 -> Done at E4, Lo=15, Hi=0; MULTU 5 x 0 -> Done at E2, Hi=Lo=0.
